// File: rtl/serdes_pkg.sv
// serdes_pkg: shared FSM state type and length-width helper for the frame serializer
package serdes_pkg;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} ser_state_e;
   function automatic int len_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/cmn_EnResetReg.sv
// cmn_EnResetReg: enable register with synchronous active-high clear
module cmn_EnResetReg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   // clear on reset, capture on enable, otherwise hold
   always_ff @(posedge clk) o_q <= reset ? '0 : i_en ? i_d : o_q;
endmodule

// File: rtl/serdes_FrameSlot.sv
// serdes_FrameSlot: one frame buffer (words, length, reverse flag) loaded as a unit
module serdes_FrameSlot import serdes_pkg::*; #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8,
   parameter int LEN_W     = len_w(8)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_load,
   input  logic [BIT_WIDTH-1:0] i_words [N_SAMPLES],
   input  logic [LEN_W-1:0]     i_len,
   input  logic                 i_rev,
   output logic [BIT_WIDTH-1:0] o_words [N_SAMPLES],
   output logic [LEN_W-1:0]     o_len,
   output logic                 o_rev
);
   genvar w;
   generate
      for (w = 0; w < N_SAMPLES; w++) begin : g_word
         cmn_EnResetReg #(.W(BIT_WIDTH)) u_word (
            .clk(clk), .reset(reset), .i_en(i_load), .i_d(i_words[w]), .o_q(o_words[w])
         );
      end
   endgenerate
   cmn_EnResetReg #(.W(LEN_W)) u_len (
      .clk(clk), .reset(reset), .i_en(i_load), .i_d(i_len), .o_q(o_len)
   );
   cmn_EnResetReg #(.W(1)) u_rev (
      .clk(clk), .reset(reset), .i_en(i_load), .i_d(i_rev), .o_q(o_rev)
   );
endmodule

// File: rtl/serdes_frame_serializer.sv
// serdes_frame_serializer: double-buffered variable-length frame to word serializer; SERDES_SERIALIZER_REVERSE_EN adds per-frame reverse order
module serdes_frame_serializer import serdes_pkg::*; #(
   parameter  int BIT_WIDTH = 32,
   parameter  int N_SAMPLES = 8,
   localparam int LEN_W     = len_w(N_SAMPLES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES],
   input  logic [LEN_W-1:0]     recv_len,
`ifdef SERDES_SERIALIZER_REVERSE_EN
   input  logic                 recv_rev,
`endif
   input  logic                 recv_val,
   output logic                 recv_rdy,
   output logic [BIT_WIDTH-1:0] send_msg,
   output logic                 send_val,
   input  logic                 send_rdy,
   output logic                 send_last
);
   localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
   ser_state_e           r_state;
   logic [IDX_W-1:0]     r_idx;
   logic [BIT_WIDTH-1:0] w_act_words [N_SAMPLES];
   logic [BIT_WIDTH-1:0] w_pend_words [N_SAMPLES];
   logic [BIT_WIDTH-1:0] w_act_d [N_SAMPLES];
   logic [LEN_W-1:0]     w_len_in, w_act_len, w_pend_len, w_act_len_d, w_pos, w_addr;
   logic                 w_rev_in, w_act_rev, w_pend_rev, w_act_rev_d;
   logic                 w_acc, w_fire, w_fin, w_act_load, w_pend_load;
`ifdef SERDES_SERIALIZER_REVERSE_EN
   assign w_rev_in = recv_rev;
`else
   assign w_rev_in = 1'b0;
`endif
   // handshakes, slot load steering, output decode
   always_comb begin
      w_len_in    = (recv_len > LEN_W'(N_SAMPLES)) ? LEN_W'(N_SAMPLES) : recv_len;
      recv_rdy    = r_state != TWO;
      send_val    = r_state != EMPTY;
      w_pos       = LEN_W'(r_idx);
      send_last   = send_val && (w_pos == w_act_len - LEN_W'(1));
      w_addr      = w_act_rev ? w_act_len - LEN_W'(1) - w_pos : w_pos;
      send_msg    = (w_addr < LEN_W'(N_SAMPLES)) ? w_act_words[IDX_W'(w_addr)] : '0;
      w_acc       = recv_val && recv_rdy && (w_len_in != '0);
      w_fire      = send_val && send_rdy;
      w_fin       = w_fire && send_last;
      w_act_load  = (w_acc && (r_state == EMPTY || (r_state == ONE && w_fin))) || (r_state == TWO && w_fin);
      w_pend_load = w_acc && r_state == ONE && !w_fin;
      w_act_len_d = (r_state == TWO) ? w_pend_len : w_len_in;
      w_act_rev_d = (r_state == TWO) ? w_pend_rev : w_rev_in;
      for (int i = 0; i < N_SAMPLES; i++) w_act_d[i] = (r_state == TWO) ? w_pend_words[i] : recv_msg[i];
   end
   serdes_FrameSlot #(.BIT_WIDTH(BIT_WIDTH), .N_SAMPLES(N_SAMPLES), .LEN_W(LEN_W)) u_act (
      .clk(clk), .reset(reset), .i_load(w_act_load), .i_words(w_act_d), .i_len(w_act_len_d),
      .i_rev(w_act_rev_d), .o_words(w_act_words), .o_len(w_act_len), .o_rev(w_act_rev)
   );
   serdes_FrameSlot #(.BIT_WIDTH(BIT_WIDTH), .N_SAMPLES(N_SAMPLES), .LEN_W(LEN_W)) u_pend (
      .clk(clk), .reset(reset), .i_load(w_pend_load), .i_words(recv_msg), .i_len(w_len_in),
      .i_rev(w_rev_in), .o_words(w_pend_words), .o_len(w_pend_len), .o_rev(w_pend_rev)
   );
   // slot-occupancy FSM and emitted-word counter of the draining frame
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= EMPTY;
         r_idx   <= '0;
      end else begin
         unique case (r_state)
            EMPTY:   if (w_acc) r_state <= ONE;
            ONE:     r_state <= (w_fin && !w_acc) ? EMPTY : (!w_fin && w_acc) ? TWO : ONE;
            TWO:     if (w_fin) r_state <= ONE;
            default: r_state <= EMPTY;
         endcase
         r_idx <= (w_fin || w_act_load) ? '0 : w_fire ? r_idx + IDX_W'(1) : r_idx;
      end
   end
endmodule

// File: tb/tb_serdes_frame_serializer.sv
// tb_serdes_frame_serializer: scoreboard bench for the frame serializer
module tb_serdes_frame_serializer;
   localparam int BW = 32;
   localparam int N  = 8;
   localparam int LW = 4;
   typedef struct packed {logic [BW-1:0] msg; logic last;} exp_t;
   logic          clk = 1'b0;
   logic          reset;
   logic [BW-1:0] recv_msg [N];
   logic [LW-1:0] recv_len;
   logic          recv_rev;
   logic          recv_val, recv_rdy;
   logic [BW-1:0] send_msg;
   logic          send_val, send_rdy, send_last;
   logic [BW-1:0] fw [N];
   exp_t          sb [$];
   exp_t          e;
   int            n_vec = 0, n_err = 0, n_words = 0, c0;
   logic          prev_stall = 1'b0, prev_last;
   logic [BW-1:0] prev_msg;
   logic [3:0]    pat = 4'b1001;
   serdes_frame_serializer #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
      .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_len(recv_len),
`ifdef SERDES_SERIALIZER_REVERSE_EN
      .recv_rev(recv_rev),
`endif
      .recv_val(recv_val), .recv_rdy(recv_rdy), .send_msg(send_msg), .send_val(send_val),
      .send_rdy(send_rdy), .send_last(send_last)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // scoreboard: push accepted frames, pop on each word handshake, watch stalls
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_val", send_val, 1);
            chk("hold_msg", send_msg, prev_msg);
            chk("hold_last", send_last, prev_last);
         end
         if (send_val && send_rdy) begin
            n_words++;
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("word_msg", send_msg, e.msg);
               chk("word_last", send_last, e.last);
            end
         end
         prev_stall = send_val && !send_rdy;
         prev_msg   = send_msg;
         prev_last  = send_last;
         if (recv_val && recv_rdy) begin
            automatic int l = (recv_len > N) ? N : int'(recv_len);
            for (int i = 0; i < l; i++) sb.push_back({recv_msg[recv_rev ? l - 1 - i : i], i == l - 1});
         end
      end
   end
   task automatic load_words(input logic [BW-1:0] base);
      for (int i = 0; i < N; i++) fw[i] = base + BW'(i);
   endtask
   task automatic put(input int len, input logic rev);
      recv_msg = fw;
      recv_len = LW'(len);
      recv_rev = rev;
      recv_val = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (recv_rdy) begin
            @(posedge clk);
            #1 recv_val = 1'b0;
            return;
         end
      end
      chk("recv_timeout", recv_rdy, 1);
      recv_val = 1'b0;
   endtask
   task automatic drain();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !send_val) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      chk("drain_timeout", sb.size(), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      reset = 1'b1; recv_val = 1'b0; recv_len = '0; recv_rev = 1'b0; send_rdy = 1'b1;
      load_words('0);
      recv_msg = fw;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_recv_rdy", recv_rdy, 1);
      chk("rst_send_val", send_val, 0);
      chk("rst_send_last", send_last, 0);
      chk("rst_send_msg", send_msg, 0);
      reset = 1'b0;
      load_words(32'h10);
      c0 = n_words;
      put(8, 1'b0);
      chk("lat_val", send_val, 1);
      chk("lat_msg", send_msg, 32'h10);
      repeat (8) @(posedge clk);
      #1;
      chk("single_count", n_words - c0, 8);
      chk("single_done", send_val, 0);
      c0 = n_words;
      load_words(32'hA0);
      put(3, 1'b0);
      load_words(32'hB0);
      put(2, 1'b0);
      chk("b2b_rdy_two", recv_rdy, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("b2b_count", n_words - c0, 5);
      chk("b2b_done", send_val, 0);
      send_rdy = 1'b0;
      load_words(32'hC0);
      put(4, 1'b0);
      for (int k = 0; k < 16; k++) begin
         send_rdy = pat[k % 4];
         @(posedge clk);
         #1;
      end
      send_rdy = 1'b1;
      drain();
      load_words(32'hD0);
      put(0, 1'b0);
      chk("len0_rdy", recv_rdy, 1);
      chk("len0_val", send_val, 0);
      c0 = n_words;
      load_words(32'hE0);
      put(15, 1'b0);
      drain();
      chk("clamp_count", n_words - c0, 8);
      load_words(32'hF0);
      put(1, 1'b0);
      chk("len1_last", send_last, 1);
      drain();
      load_words(32'h20);
      put(8, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_val", send_val, 0);
      chk("mid_rst_msg", send_msg, 0);
      chk("mid_rst_rdy", recv_rdy, 1);
      reset = 1'b0;
      load_words(32'h30);
      put(8, 1'b0);
      chk("restart_msg", send_msg, 32'h30);
      drain();
`ifdef SERDES_SERIALIZER_REVERSE_EN
      load_words(32'h1);
      put(4, 1'b1);
      chk("rev_first", send_msg, 32'h4);
      load_words(32'h50);
      put(4, 1'b0);
      drain();
`endif
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
